// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: DEPTH-byte FIFO feeding a UART transmitter through a level start/done handshake; start rises 2 cycles after a write to an idle buffer.
// Backpressure: o_wr_ready is low while full and writes then are dropped; UART_TX_BUF_OVF_FLAG_EN adds a sticky overflow flag.
module uart_tx_buffer #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_aresetn,
  input  logic          i_wr_valid,
  input  logic [7:0]    i_wr_data,
  output logic          o_wr_ready,
  output logic          o_tx_start,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_done,
  output logic [AW:0]   o_level,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_busy
`ifdef UART_TX_BUF_OVF_FLAG_EN
  ,
  input  logic          i_ovf_clr,
  output logic          o_overflow
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_acc, pop, tx_start_d;
  logic [AW:0]   level_d;

  // o_wr_ready is registered, so acceptance always reflects the pre-edge fill state
  assign wr_acc = i_wr_valid && o_wr_ready;
  assign pop    = (state_q == LOAD);

  always_comb begin
    level_d = o_level;
    if (wr_acc && !pop)
      level_d = o_level + (AW+1)'(1);
    else if (!wr_acc && pop)
      level_d = o_level - (AW+1)'(1);
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = o_tx_start;
    unique case (state_q)
      IDLE: if (!o_empty) state_d = LOAD;
      LOAD: begin
        tx_start_d = 1'b1;
        state_d    = SEND;
      end
      SEND: if (i_tx_done) begin
        tx_start_d = 1'b0;
        state_d    = (level_d != '0) ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_empty    <= 1'b1;
      o_full     <= 1'b0;
      o_wr_ready <= 1'b1;
      o_busy     <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        o_tx_data <= mem[rd_ptr];
      end
      o_tx_start <= tx_start_d;
      o_level    <= level_d;
      o_empty    <= (level_d == '0);
      o_full     <= (level_d == FULL_LVL);
      o_wr_ready <= (level_d != FULL_LVL);
      o_busy     <= (state_d != IDLE) || (level_d != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr] <= i_wr_data;
  end

`ifdef UART_TX_BUF_OVF_FLAG_EN
  // set wins over clear so a drop in the clearing cycle is not lost
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn)                 o_overflow <= 1'b0;
    else if (i_wr_valid && o_full)  o_overflow <= 1'b1;
    else if (i_ovf_clr)             o_overflow <= 1'b0;
  end
`endif

endmodule
